// File: rtl/ifetch_refill_pkg.sv
//------------------------------------------------------------------------------
// ifetch_refill_pkg : shared types and flag encodings for the I-cache refill engine
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ifetch_refill_pkg;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_REQ   = 5'b00010,
    ST_FILL  = 5'b00100,
    ST_DRAIN = 5'b01000,
    ST_DONE  = 5'b10000
  } refill_state_t;

  localparam logic [1:0] FLAG_VALID    = 2'b01;
  localparam logic [1:0] FLAG_DIRTY    = 2'b10;
  localparam logic [1:0] FLAGS_INVALID = 2'b00;
  // Instruction lines are never written by the core, so a filled line is valid and clean.
  localparam logic [1:0] FLAGS_FILLED  = FLAG_VALID & ~FLAG_DIRTY;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_refill_if.sv
//------------------------------------------------------------------------------
// ifetch_refill_if : main-bus read channel between the refill engine and the bus
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ifetch_refill_if #(
  parameter int PADDR_W = 29
);
  logic               rf_cvalid;
  logic               bmain_cready;
  logic               rf_cmd;
  logic [PADDR_W-3:0] rf_addr;
  logic               bmain_rvalid;
  logic               rf_rready;
  logic               bmain_rlast;
  logic [31:0]        bmain_rdata;
  logic               bmain_error;
  logic               rf_eack;

  modport master (
    output rf_cvalid, rf_cmd, rf_addr, rf_rready, rf_eack,
    input  bmain_cready, bmain_rvalid, bmain_rlast, bmain_rdata, bmain_error
  );

  modport slave (
    input  rf_cvalid, rf_cmd, rf_addr, rf_rready, rf_eack,
    output bmain_cready, bmain_rvalid, bmain_rlast, bmain_rdata, bmain_error
  );
endinterface

`default_nettype wire

// File: rtl/ifetch_refill_rr_victim.sv
//------------------------------------------------------------------------------
// rr_victim : round-robin victim-way pointer, advanced once per completed fill
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_victim
  import ifetch_refill_pkg::*;
#(
  parameter int WAYS = 2
) (
  input  wire logic                        clk_core,
  input  wire logic                        reset_n,
  input  wire logic                        advance,
  output logic [clog2_min1(WAYS)-1:0]      victim
);

  localparam int WAY_W = clog2_min1(WAYS);

  generate
    if (WAYS > 1) begin : g_multi
      // WAYS is a power of two, so the natural wrap of the counter is modulo WAYS.
      always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
          victim <= '0;
        end else if (advance) begin
          victim <= victim + WAY_W'(1);
        end
      end
    end else begin : g_single
      assign victim = '0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/ifetch_refill.sv
//------------------------------------------------------------------------------
// ifetch_refill : critical-word-first I-cache refill engine, round-robin victim.
// Optional: IFETCH_EARLY_RESTART_EN returns the missed word as beat 0 arrives.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ifetch_refill
  import ifetch_refill_pkg::*;
#(
  parameter int PADDR_W    = 29,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 256,
  parameter int WAYS       = 2
) (
  input  wire logic                                              clk_core,
  input  wire logic                                              reset_n,
  input  wire logic                                              miss_valid,
  input  wire logic [PADDR_W-3:0]                                miss_addr,
  output logic                                                   miss_ready,
  input  wire logic                                              kill,
  output logic                                                   rf_busy,
  output logic                                                   rf_insn_valid,
  output logic [31:0]                                            rf_insn,
  output logic                                                   rf_exc,
  ifetch_refill_if.master                                        bus,
  output logic                                                   rf_data_we,
  output logic [clog2_min1(WAYS)-1:0]                            rf_data_way,
  output logic [$clog2(SETS)+$clog2(LINE_WORDS)-1:0]             rf_data_index,
  output logic [31:0]                                            rf_data_wdata,
  output logic                                                   rf_tag_we,
  output logic [clog2_min1(WAYS)-1:0]                            rf_tag_way,
  output logic [$clog2(SETS)-1:0]                                rf_tag_index,
  output logic [PADDR_W-2-$clog2(LINE_WORDS)-$clog2(SETS)-1:0]   rf_tag,
  output logic [1:0]                                             rf_flags
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = clog2_min1(WAYS);
  localparam int TAG_W = PADDR_W - 2 - OFF_W - IDX_W;
  localparam int WA_W  = PADDR_W - 2;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  refill_state_t    state_q, state_d;
  logic [WA_W-1:0]  addr_q;
  logic [WAY_W-1:0] way_q;
  logic [OFF_W-1:0] off_q;
  logic [OFF_W-1:0] beat_q;
  logic [31:0]      insn_q;
  logic [WAY_W-1:0] victim;
  logic             accept;
  logic             beat_wr;
  logic             advance;

  logic [IDX_W-1:0] miss_set, set_q;
  logic [TAG_W-1:0] miss_tag, tag_q;

  assign miss_set = miss_addr[OFF_W+IDX_W-1:OFF_W];
  assign miss_tag = miss_addr[WA_W-1:OFF_W+IDX_W];
  assign set_q    = addr_q[OFF_W+IDX_W-1:OFF_W];
  assign tag_q    = addr_q[WA_W-1:OFF_W+IDX_W];

  rr_victim #(
    .WAYS (WAYS)
  ) u_victim (
    .clk_core (clk_core),
    .reset_n  (reset_n),
    .advance  (advance),
    .victim   (victim)
  );

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      way_q   <= '0;
      off_q   <= '0;
      beat_q  <= '0;
      insn_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= miss_addr;
        way_q  <= victim;
        off_q  <= miss_addr[OFF_W-1:0];
        beat_q <= '0;
      end else if (beat_wr) begin
        off_q  <= off_q + OFF_W'(1);
        beat_q <= beat_q + OFF_W'(1);
        if (beat_q == '0) begin
          insn_q <= bus.bmain_rdata;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    beat_wr       = 1'b0;
    advance       = 1'b0;
    miss_ready    = 1'b0;
    rf_insn_valid = 1'b0;
    rf_exc        = 1'b0;
    bus.rf_cvalid = 1'b0;
    bus.rf_rready = 1'b0;
    rf_tag_we     = 1'b0;
    rf_tag_way    = way_q;
    rf_tag_index  = set_q;
    rf_tag        = tag_q;
    rf_flags      = FLAGS_INVALID;

    unique case (state_q)
      ST_IDLE: begin
        miss_ready = ~bus.bmain_error;
        if (bus.bmain_error) begin
          rf_exc = 1'b1;
        end else if (miss_valid && !kill) begin
          // Invalidate the victim up front so a half-filled line can never hit.
          accept       = 1'b1;
          rf_tag_we    = 1'b1;
          rf_tag_way   = victim;
          rf_tag_index = miss_set;
          rf_tag       = miss_tag;
          state_d      = ST_REQ;
        end
      end

      ST_REQ: begin
        bus.rf_cvalid = 1'b1;
        if (bus.bmain_error) begin
          rf_exc  = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.bmain_cready) begin
          // A command accepted alongside kill still produces a burst that must be drained.
          state_d = kill ? ST_DRAIN : ST_FILL;
        end else if (kill) begin
          state_d = ST_IDLE;
        end
      end

      ST_FILL: begin
        bus.rf_rready = 1'b1;
        if (bus.bmain_error) begin
          rf_exc  = 1'b1;
          state_d = ST_IDLE;
        end else if (kill) begin
          state_d = (bus.bmain_rvalid && bus.bmain_rlast) ? ST_IDLE : ST_DRAIN;
        end else if (bus.bmain_rvalid) begin
`ifdef IFETCH_EARLY_RESTART_EN
          if (beat_q == '0) begin
            rf_insn_valid = 1'b1;
          end
`endif
          if (bus.bmain_rlast != (beat_q == LAST_BEAT)) begin
            rf_exc  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            beat_wr = 1'b1;
            if (beat_q == LAST_BEAT) begin
              rf_tag_we = 1'b1;
              rf_flags  = FLAGS_FILLED;
              advance   = 1'b1;
`ifdef IFETCH_EARLY_RESTART_EN
              state_d   = ST_IDLE;
`else
              state_d   = ST_DONE;
`endif
            end
          end
        end
      end

      ST_DRAIN: begin
        bus.rf_rready = 1'b1;
        if (bus.bmain_error || (bus.bmain_rvalid && bus.bmain_rlast)) begin
          state_d = ST_IDLE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.bmain_error) begin
          // The tag was just marked valid; take it back so the line stays invalid.
          rf_exc    = 1'b1;
          rf_tag_we = 1'b1;
        end else begin
          rf_insn_valid = ~kill;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef IFETCH_EARLY_RESTART_EN
  assign rf_insn = (state_q == ST_FILL && beat_q == '0) ? bus.bmain_rdata : insn_q;
`else
  assign rf_insn = insn_q;
`endif

  assign rf_busy       = (state_q != ST_IDLE);
  assign bus.rf_cmd    = 1'b1;
  assign bus.rf_addr   = addr_q;
  assign bus.rf_eack   = bus.bmain_error;
  assign rf_data_we    = beat_wr;
  assign rf_data_way   = way_q;
  assign rf_data_index = {set_q, off_q};
  assign rf_data_wdata = beat_wr ? bus.bmain_rdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_refill.sv
//------------------------------------------------------------------------------
// tb_ifetch_refill : directed stimulus with a queue-based scoreboard and monitor
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ifetch_refill;
  import ifetch_refill_pkg::*;

  localparam int PADDR_W    = 29;
  localparam int LINE_WORDS = 4;
  localparam int SETS       = 256;
  localparam int WAYS       = 2;
  localparam int WA_W       = PADDR_W - 2;
  localparam int OFF_W      = 2;
  localparam int IDX_W      = 8;
  localparam int WAY_W      = 1;
  localparam int TAG_W      = WA_W - OFF_W - IDX_W;
`ifdef IFETCH_EARLY_RESTART_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic               clk_core = 1'b0;
  logic               reset_n  = 1'b0;
  logic               miss_valid = 1'b0;
  logic [WA_W-1:0]    miss_addr  = '0;
  logic               kill       = 1'b0;
  logic               miss_ready, rf_busy, rf_insn_valid, rf_exc;
  logic [31:0]        rf_insn, rf_data_wdata;
  logic               rf_data_we, rf_tag_we;
  logic [WAY_W-1:0]   rf_data_way, rf_tag_way;
  logic [IDX_W+OFF_W-1:0] rf_data_index;
  logic [IDX_W-1:0]   rf_tag_index;
  logic [TAG_W-1:0]   rf_tag;
  logic [1:0]         rf_flags;

  ifetch_refill_if #(.PADDR_W(PADDR_W)) bus ();

  ifetch_refill #(
    .PADDR_W(PADDR_W), .LINE_WORDS(LINE_WORDS), .SETS(SETS), .WAYS(WAYS)
  ) dut (
    .clk_core(clk_core), .reset_n(reset_n), .miss_valid(miss_valid), .miss_addr(miss_addr),
    .miss_ready(miss_ready), .kill(kill), .rf_busy(rf_busy), .rf_insn_valid(rf_insn_valid),
    .rf_insn(rf_insn), .rf_exc(rf_exc), .bus(bus.master), .rf_data_we(rf_data_we),
    .rf_data_way(rf_data_way), .rf_data_index(rf_data_index), .rf_data_wdata(rf_data_wdata),
    .rf_tag_we(rf_tag_we), .rf_tag_way(rf_tag_way), .rf_tag_index(rf_tag_index),
    .rf_tag(rf_tag), .rf_flags(rf_flags)
  );

  always #5 clk_core = ~clk_core;

  int cyc = 0;
  always @(posedge clk_core) cyc <= cyc + 1;

  typedef struct { int cyc; int way; int idx; logic [31:0] val; } wr_t;
  typedef struct { int cyc; logic [31:0] val; } ev_t;
  typedef struct { int cyc; logic busy; logic ready; logic zero; } st_t;

  wr_t q_data[$];
  wr_t q_tag[$];
  ev_t q_insn[$];
  ev_t q_exc[$];
  ev_t q_cmd[$];
  st_t q_st[$];
  int  n_checks = 0;
  int  n_errors = 0;

  initial begin
    bus.bmain_cready = 1'b0;
    bus.bmain_rvalid = 1'b0;
    bus.bmain_rlast  = 1'b0;
    bus.bmain_rdata  = '0;
    bus.bmain_error  = 1'b0;
  end

  // ---------------- monitor ----------------
  task automatic cmp_wr(input string nm, input wr_t e, input int way, input int idx, input logic [31:0] val);
    n_checks++;
    if (e.cyc != cyc || e.way != way || e.idx != idx || e.val != val) begin
      n_errors++;
      $display("FAIL %s: got cyc=%0d way=%0d idx=0x%0h val=0x%08h, expected cyc=%0d way=%0d idx=0x%0h val=0x%08h",
               nm, cyc, way, idx, val, e.cyc, e.way, e.idx, e.val);
    end
  endtask

  task automatic cmp_ev(input string nm, input ev_t e, input logic [31:0] val);
    n_checks++;
    if (e.cyc != cyc || e.val != val) begin
      n_errors++;
      $display("FAIL %s: got cyc=%0d val=0x%08h, expected cyc=%0d val=0x%08h", nm, cyc, val, e.cyc, e.val);
    end
  endtask

  task automatic unexpected(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL unexpected_%s: got a pulse at cyc=%0d, expected none", nm, cyc);
  endtask

  always @(negedge clk_core) begin
    st_t s;
    if (rf_data_we) begin
      if (q_data.size() == 0) unexpected("data_we");
      else cmp_wr("data_write", q_data.pop_front(), int'(rf_data_way), int'(rf_data_index), rf_data_wdata);
    end
    if (rf_tag_we) begin
      if (q_tag.size() == 0) unexpected("tag_we");
      else cmp_wr("tag_write", q_tag.pop_front(), int'(rf_tag_way), int'(rf_tag_index), {13'd0, rf_flags, rf_tag});
    end
    if (rf_insn_valid) begin
      if (q_insn.size() == 0) unexpected("insn_valid");
      else cmp_ev("insn", q_insn.pop_front(), rf_insn);
    end
    if (rf_exc) begin
      if (q_exc.size() == 0) unexpected("exc");
      else cmp_ev("exc", q_exc.pop_front(), 32'd0);
    end
    if (bus.rf_cvalid && bus.bmain_cready) begin
      if (q_cmd.size() == 0) unexpected("cmd");
      else cmp_ev("cmd_addr", q_cmd.pop_front(), 32'(bus.rf_addr));
    end
    if (bus.bmain_error || bus.rf_eack) begin
      n_checks++;
      if (bus.rf_eack !== bus.bmain_error) begin
        n_errors++;
        $display("FAIL eack: got %b, expected %b at cyc=%0d", bus.rf_eack, bus.bmain_error, cyc);
      end
    end
    while (q_st.size() > 0 && q_st[0].cyc <= cyc) begin
      s = q_st.pop_front();
      n_checks++;
      if (s.cyc != cyc || rf_busy !== s.busy || miss_ready !== s.ready) begin
        n_errors++;
        $display("FAIL status: got cyc=%0d busy=%b ready=%b, expected cyc=%0d busy=%b ready=%b",
                 cyc, rf_busy, miss_ready, s.cyc, s.busy, s.ready);
      end
      if (s.zero) begin
        n_checks++;
        if ({rf_insn_valid, rf_exc, bus.rf_eack, bus.rf_cvalid, bus.rf_rready, rf_data_we, rf_tag_we,
             rf_insn, bus.rf_addr, rf_data_index, rf_data_wdata, rf_tag, rf_tag_index,
             rf_tag_way, rf_data_way, rf_flags} != '0) begin
          n_errors++;
          $display("FAIL reset_outputs: got nonzero outputs at cyc=%0d, expected all zero", cyc);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic push_tag(input int c, input int way, input int set_i, input logic [1:0] fl, input logic [TAG_W-1:0] tg);
    q_tag.push_back('{c, way, set_i, {13'd0, fl, tg}});
  endtask

  task automatic clear_bus();
    bus.bmain_cready = 1'b0;
    bus.bmain_rvalid = 1'b0;
    bus.bmain_rlast  = 1'b0;
    bus.bmain_error  = 1'b0;
    kill             = 1'b0;
  endtask

  task automatic run_miss(input logic [WA_W-1:0] a, input int way, input logic [31:0] dbase,
                          input int cwait, input int gap, input int kill_at, input int err_at, input int last_at);
    int set_i, off_i;
    logic [TAG_W-1:0] tg;
    logic [31:0] d0, d;
    bit draining, ended, ok;
    set_i = int'(a[OFF_W+IDX_W-1:OFF_W]);
    off_i = int'(a[OFF_W-1:0]);
    tg    = a[WA_W-1:OFF_W+IDX_W];
    d0 = '0; draining = 0; ended = 0; ok = 0;
    push_tag(cyc, way, set_i, 2'b00, tg);
    miss_valid = 1'b1;
    miss_addr  = a;
    tick();
    miss_valid = 1'b0;
    repeat (cwait) tick();
    bus.bmain_cready = 1'b1;
    q_cmd.push_back('{cyc, 32'(a)});
    tick();
    bus.bmain_cready = 1'b0;
    for (int b = 0; b < LINE_WORDS && !ended; b++) begin
      if (b > 0) repeat (gap) tick();
      d = dbase + 32'(b);
      bus.bmain_rvalid = 1'b1;
      bus.bmain_rdata  = d;
      bus.bmain_rlast  = (b == last_at);
      bus.bmain_error  = (b == err_at);
      kill             = (b == kill_at);
      if (draining) begin
        if (b == err_at || b == last_at) ended = 1;
      end else if (b == err_at) begin
        q_exc.push_back('{cyc, 32'd0});
        ended = 1;
      end else if (b == kill_at) begin
        draining = 1;
        if (b == last_at) ended = 1;
      end else begin
        if (EARLY && b == 0) q_insn.push_back('{cyc, d});
        if ((b == last_at) != (b == LINE_WORDS - 1)) begin
          q_exc.push_back('{cyc, 32'd0});
          ended = 1;
        end else begin
          q_data.push_back('{cyc, way, set_i * LINE_WORDS + (off_i + b) % LINE_WORDS, d});
          if (b == 0) d0 = d;
          if (b == LINE_WORDS - 1) begin
            push_tag(cyc, way, set_i, 2'b01, tg);
            ok = 1;
          end
        end
      end
      tick();
      clear_bus();
    end
    if (ok && !EARLY) begin
      q_insn.push_back('{cyc, d0});
      q_st.push_back('{cyc, 1'b1, 1'b0, 1'b0});
      tick();
    end
    q_st.push_back('{cyc, 1'b0, 1'b1, 1'b0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus by 200000, expected earlier finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WA_W-1:0] a;
    repeat (3) @(posedge clk_core);
    #1;
    reset_n = 1'b1;
    q_st.push_back('{cyc, 1'b0, 1'b1, 1'b1});
    tick();

    // Critical word at offset 2, then two more misses to the same set: ways 0,1,0.
    run_miss({17'h0ABCD, 8'h5A, 2'd2}, 0, 32'hDEADBEEF, 0, 0, -1, -1, 3);
    run_miss({17'h01234, 8'h5A, 2'd0}, 1, 32'h11110000, 0, 0, -1, -1, 3);
    run_miss({17'h1FFFF, 8'h5A, 2'd3}, 0, 32'h22220000, 0, 0, -1, -1, 3);
    // Kill on 2nd beat, error on 3rd beat, early rlast on beat 1: victim stays at way 1.
    run_miss({17'h00042, 8'h10, 2'd1}, 1, 32'h33330000, 0, 0, 1, -1, 3);
    run_miss({17'h00043, 8'h11, 2'd0}, 1, 32'h44440000, 0, 0, -1, 2, 3);
    run_miss({17'h00044, 8'h12, 2'd3}, 1, 32'h55550000, 0, 0, -1, -1, 1);

    // Kill while the command is still pending.
    a = {17'h00045, 8'h13, 2'd0};
    push_tag(cyc, 1, 8'h13, 2'b00, a[WA_W-1:OFF_W+IDX_W]);
    miss_valid = 1'b1; miss_addr = a;
    tick();
    miss_valid = 1'b0; kill = 1'b1;
    tick();
    kill = 1'b0;
    q_st.push_back('{cyc, 1'b0, 1'b1, 1'b0});

    // Kill in IDLE blocks acceptance.
    miss_valid = 1'b1; kill = 1'b1; miss_addr = {17'h00046, 8'h14, 2'd0};
    q_st.push_back('{cyc, 1'b0, 1'b1, 1'b0});
    tick();
    miss_valid = 1'b0; kill = 1'b0;
    q_st.push_back('{cyc, 1'b0, 1'b1, 1'b0});
    tick();

    // Reset mid-burst: back to IDLE at once, victim pointer back to way 0.
    a = {17'h00047, 8'h15, 2'd1};
    push_tag(cyc, 1, 8'h15, 2'b00, a[WA_W-1:OFF_W+IDX_W]);
    miss_valid = 1'b1; miss_addr = a;
    tick();
    miss_valid = 1'b0; bus.bmain_cready = 1'b1;
    q_cmd.push_back('{cyc, 32'(a)});
    tick();
    clear_bus();
    bus.bmain_rvalid = 1'b1; bus.bmain_rdata = 32'h66660000;
    q_data.push_back('{cyc, 1, 8'h15 * LINE_WORDS + 1, 32'h66660000});
    if (EARLY) q_insn.push_back('{cyc, 32'h66660000});
    tick();
    clear_bus();
    miss_addr = '0;
    reset_n = 1'b0;
    q_st.push_back('{cyc, 1'b0, 1'b1, 1'b1});
    tick();
    reset_n = 1'b1;
    tick();

    // Bus wait states on command and between beats.
    run_miss({17'h00100, 8'hC3, 2'd3}, 0, 32'h77770000, 2, 1, -1, -1, 3);
    run_miss({17'h00101, 8'hC3, 2'd1}, 1, 32'h88880000, 0, 0, -1, -1, 3);
    repeat (3) tick();

    n_checks++; if (q_data.size() != 0) begin n_errors++; $display("FAIL data_drain: got %0d pending, expected 0", q_data.size()); end
    n_checks++; if (q_tag.size()  != 0) begin n_errors++; $display("FAIL tag_drain: got %0d pending, expected 0", q_tag.size()); end
    n_checks++; if (q_insn.size() != 0) begin n_errors++; $display("FAIL insn_drain: got %0d pending, expected 0", q_insn.size()); end
    n_checks++; if (q_exc.size()  != 0) begin n_errors++; $display("FAIL exc_drain: got %0d pending, expected 0", q_exc.size()); end
    n_checks++; if (q_cmd.size()  != 0) begin n_errors++; $display("FAIL cmd_drain: got %0d pending, expected 0", q_cmd.size()); end
    n_checks++; if (q_st.size()   != 0) begin n_errors++; $display("FAIL status_drain: got %0d pending, expected 0", q_st.size()); end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
